// File: rtl/led_arb_pkg.sv
// Shared definitions for the LED display arbiter: mode encodings, FSM states
// and frame timing constants.
package led_arb_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_CODE  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ON_PH  = 2'd1,
    OFF_PH = 2'd2,
    GAP    = 2'd3
  } state_t;

  localparam int C_BLINK_HALF = 4;
  localparam int C_CODE_GAP   = 8;
  localparam int C_PH_W       = 3;

  // Phase counters hold "ticks remaining minus one".
  function automatic logic [C_PH_W-1:0] ph_load(input int ticks);
    return C_PH_W'(ticks - 1);
  endfunction

endpackage

// File: rtl/led_tick.sv
// Pattern tick generator: one-cycle tick every C_TICK_DIV clocks, counter
// restarts from zero on reset.
module led_tick #(
  parameter int C_TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = (C_TICK_DIV > 1) ? $clog2(C_TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt_reg;

  assign tick = (cnt_reg == CNT_W'(C_TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/led_arb.sv
// Priority arbiter sharing one status LED between requesters, each frame
// showing OFF/ON/BLINK/CODE patterns. Build option: LED_ARB_PREEMPT_EN.
module led_arb
  import led_arb_pkg::*;
#(
  parameter int C_CLK_FREQ = 125000000,
  parameter int C_TICK_DIV = C_CLK_FREQ / 8,
  parameter int C_NUM_REQ  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [C_NUM_REQ-1:0]   req,
  input  logic [2*C_NUM_REQ-1:0] req_mode,
  input  logic [4*C_NUM_REQ-1:0] req_count,
  output logic [C_NUM_REQ-1:0]   grant,
  output logic                   led
);

  localparam logic [C_NUM_REQ-1:0] C_ONE = C_NUM_REQ'(1);

  logic tick;

  led_tick #(
    .C_TICK_DIV(C_TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  state_t                state_reg, state_next;
  logic                  led_reg, led_next;
  logic [C_NUM_REQ-1:0]  grant_reg, grant_next;
  mode_t                 mode_reg, mode_next;
  logic [3:0]            count_reg, count_next;
  logic [C_PH_W-1:0]     ph_reg, ph_next;
  logic [3:0]            rep_reg, rep_next;

  logic [C_NUM_REQ-1:0]  first;
  logic [1:0]            sel_mode_bits;
  logic [3:0]            sel_count;
  logic [4:0]            code_n;
  logic                  preempt;
  logic                  frame_end;

  // Isolate the lowest set request bit (highest priority).
  assign first = req & ~(req - C_ONE);

  always_comb begin
    sel_mode_bits = '0;
    sel_count     = '0;
    for (int i = 0; i < C_NUM_REQ; i++) begin
      if (first[i]) begin
        sel_mode_bits = req_mode[2*i +: 2];
        sel_count     = req_count[4*i +: 4];
      end
    end
  end

`ifdef LED_ARB_PREEMPT_EN
  // grant_reg - 1 masks every requester of higher priority than the owner.
  assign preempt = (state_reg != IDLE) && (|(req & (grant_reg - C_ONE)));
`else
  assign preempt = 1'b0;
`endif

  // A latched count of zero still produces one pulse.
  assign code_n = (count_reg == 4'd0) ? 5'd1 : {1'b0, count_reg};

  always_comb begin
    state_next = state_reg;
    led_next   = led_reg;
    grant_next = grant_reg;
    mode_next  = mode_reg;
    count_next = count_reg;
    ph_next    = ph_reg;
    rep_next   = rep_reg;
    frame_end  = 1'b0;

    if (tick) begin
      case (state_reg)
        ON_PH: begin
          if (ph_reg != '0) begin
            ph_next = ph_reg - C_PH_W'(1);
          end else if (mode_reg == MODE_BLINK) begin
            state_next = OFF_PH;
            led_next   = 1'b0;
            ph_next    = ph_load(C_BLINK_HALF);
          end else if (mode_reg == MODE_CODE) begin
            state_next = OFF_PH;
            led_next   = 1'b0;
            ph_next    = '0;
          end else begin
            frame_end = 1'b1;
          end
        end
        OFF_PH: begin
          if (ph_reg != '0) begin
            ph_next = ph_reg - C_PH_W'(1);
          end else if (mode_reg == MODE_CODE) begin
            if ({1'b0, rep_reg} + 5'd1 < code_n) begin
              rep_next   = rep_reg + 4'd1;
              state_next = ON_PH;
              led_next   = 1'b1;
            end else begin
              state_next = GAP;
              ph_next    = ph_load(C_CODE_GAP);
            end
          end else begin
            frame_end = 1'b1;
          end
        end
        GAP: begin
          if (ph_reg != '0) begin
            ph_next = ph_reg - C_PH_W'(1);
          end else begin
            frame_end = 1'b1;
          end
        end
        default: ;
      endcase

      // Frame start overrides any continuation decided above.
      if (state_reg == IDLE || frame_end || preempt) begin
        ph_next  = '0;
        rep_next = '0;
        if (req == '0) begin
          state_next = IDLE;
          led_next   = 1'b0;
          grant_next = '0;
          mode_next  = MODE_OFF;
          count_next = '0;
        end else begin
          grant_next = first;
          mode_next  = mode_t'(sel_mode_bits);
          count_next = sel_count;
          case (mode_t'(sel_mode_bits))
            MODE_OFF: begin
              state_next = OFF_PH;
              led_next   = 1'b0;
            end
            MODE_BLINK: begin
              state_next = ON_PH;
              led_next   = 1'b1;
              ph_next    = ph_load(C_BLINK_HALF);
            end
            default: begin
              state_next = ON_PH;
              led_next   = 1'b1;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      led_reg   <= 1'b0;
      grant_reg <= '0;
      mode_reg  <= MODE_OFF;
      count_reg <= '0;
      ph_reg    <= '0;
      rep_reg   <= '0;
    end else begin
      state_reg <= state_next;
      led_reg   <= led_next;
      grant_reg <= grant_next;
      mode_reg  <= mode_next;
      count_reg <= count_next;
      ph_reg    <= ph_next;
      rep_reg   <= rep_next;
    end
  end

  assign grant = grant_reg;
  assign led   = led_reg;

endmodule

// File: tb/tb_led_arb.sv
// Self-checking bench for led_arb: a per-tick pattern-list model fills a
// scoreboard that is compared against grant/led every cycle.
module tb_led_arb;

  localparam int DIV = 4;
  localparam int N   = 4;
  localparam logic [1:0] M_OFF   = 2'd0;
  localparam logic [1:0] M_ON    = 2'd1;
  localparam logic [1:0] M_BLINK = 2'd2;
  localparam logic [1:0] M_CODE  = 2'd3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [2*N-1:0] req_mode = '0;
  logic [4*N-1:0] req_count = '0;
  logic [N-1:0]   grant;
  logic           led;

  led_arb #(
    .C_CLK_FREQ(125000000),
    .C_TICK_DIV(DIV),
    .C_NUM_REQ (N)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_mode (req_mode),
    .req_count(req_count),
    .grant    (grant),
    .led      (led)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: a frame is a list of LED values, one per tick.
  typedef struct packed {
    logic [N-1:0] g;
    logic         l;
  } exp_t;

  int           tcnt = 0;
  int           cur = -1;
  bit           plan[$];
  logic         exp_led = 1'b0;
  logic [N-1:0] exp_grant = '0;
  exp_t         sb[$];

  task automatic build_plan(input logic [1:0] m, input logic [3:0] c);
    int n;
    plan.delete();
    case (m)
      M_OFF: plan.push_back(1'b0);
      M_ON:  plan.push_back(1'b1);
      M_BLINK: begin
        repeat (4) plan.push_back(1'b1);
        repeat (4) plan.push_back(1'b0);
      end
      default: begin
        n = (c == 4'd0) ? 1 : int'(c);
        repeat (n) begin
          plan.push_back(1'b1);
          plan.push_back(1'b0);
        end
        repeat (8) plan.push_back(1'b0);
      end
    endcase
  endtask

  task automatic model_step();
    bit tk;
    bit pre;
    int w;
    if (rst) begin
      tcnt = 0;
      cur = -1;
      plan.delete();
      exp_led = 1'b0;
      exp_grant = '0;
    end else begin
      tk = (tcnt == DIV - 1);
      tcnt = tk ? 0 : tcnt + 1;
      if (tk) begin
        pre = 1'b0;
`ifdef LED_ARB_PREEMPT_EN
        for (int i = 0; i < cur; i++) if (req[i]) pre = 1'b1;
`endif
        if (cur < 0 || plan.size() == 0 || pre) begin
          w = -1;
          for (int i = N - 1; i >= 0; i--) if (req[i]) w = i;
          if (w < 0) begin
            cur = -1;
            plan.delete();
            exp_grant = '0;
          end else begin
            cur = w;
            build_plan(req_mode[2*w +: 2], req_count[4*w +: 4]);
            exp_grant = N'(1) << w;
          end
        end
        exp_led = (cur >= 0) ? plan.pop_front() : 1'b0;
        $display("tick t=%0t req=%b exp_grant=%b exp_led=%b", $time, req, exp_grant, exp_led);
      end
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      model_step();
      sb.push_back('{g: exp_grant, l: exp_led});
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("grant", 32'(grant), 32'(e.g));
        check("led", 32'(led), 32'(e.l));
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_req(input int i, input bit on, input logic [1:0] m, input logic [3:0] c);
    req[i] = on;
    req_mode[2*i +: 2] = m;
    req_count[4*i +: 4] = c;
  endtask

  task automatic wait_grant(input logic [N-1:0] g, input string tag);
    int n = 0;
    while (exp_grant !== g && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({tag, "_timeout"}, 32'(exp_grant), 32'(g));
    check(tag, 32'(grant), 32'(g));
  endtask

  initial begin
    rst = 1'b1;
    cycles(3);
    check("reset_grant", 32'(grant), 32'h0);
    check("reset_led", 32'(led), 32'h0);
    rst = 1'b0;

    // Single BLINK requester
    set_req(0, 1'b1, M_BLINK, 4'd0);
    wait_grant(4'b0001, "blink_grant");
    cycles(80);

    // CODE with count 3 takes over after the BLINK frame
    set_req(0, 1'b0, M_OFF, 4'd0);
    set_req(1, 1'b1, M_CODE, 4'd3);
    wait_grant(4'b0010, "code3_grant");
    cycles(120);

    // Higher priority request raised at frame tick 2 of a BLINK frame
    set_req(1, 1'b0, M_OFF, 4'd0);
    set_req(2, 1'b1, M_BLINK, 4'd0);
    wait_grant(4'b0100, "blink2_grant");
    cycles(8);
    set_req(0, 1'b1, M_ON, 4'd0);
    wait_grant(4'b0001, "hiprio_grant");
    cycles(20);
    set_req(0, 1'b0, M_OFF, 4'd0);
    set_req(2, 1'b0, M_OFF, 4'd0);
    cycles(40);

    // req dropped mid CODE frame
    set_req(1, 1'b1, M_CODE, 4'd2);
    wait_grant(4'b0010, "code2_grant");
    cycles(6);
    set_req(1, 1'b0, M_CODE, 4'd2);
    cycles(60);
    check("idle_grant", 32'(grant), 32'h0);
    check("idle_led", 32'(led), 32'h0);

    // Reset pulse while in ON phase
    set_req(3, 1'b1, M_ON, 4'd0);
    wait_grant(4'b1000, "on_grant");
    cycles(1);
    rst = 1'b1;
    cycles(1);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    rst = 1'b0;
    cycles(30);
    set_req(3, 1'b0, M_OFF, 4'd0);

    // CODE with count 0 behaves as count 1
    set_req(0, 1'b1, M_CODE, 4'd0);
    wait_grant(4'b0001, "code0_grant");
    cycles(60);
    set_req(0, 1'b0, M_OFF, 4'd0);
    cycles(10);

    // Random traffic, including mid-frame mode/count changes
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_req(int'($urandom_range(0, N - 1)), 1'($urandom_range(0, 1)),
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
      end
      cycles(1);
    end

    cycles(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
